reaction_ctrl: RTL and testbench

Controller for the reaction-timer datapath, sitting directly upstream of the delay stage. It drives that stage's trigger and N inputs and consumes its time_out. It sequences the LED countdown, requests a pseudo-random hold-off from the delay stage, then measures the user's reaction time as 4-digit BCD. The system clk in this subsystem is the 1 kHz tick, so 1 cycle = 1 ms.

---
 rtl/reaction_ctrl_if.sv | 24 ++
 rtl/reaction_ctrl.sv | 164 ++++++++++++++++
 tb/tb_reaction_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/reaction_ctrl_if.sv
// Signal bundle between the reaction-timer controller and its surroundings:
// buttons, the delay-stage trigger/N/time_out link, and the result outputs.
interface reaction_ctrl_if;
    logic        start;
    logic        react;
    logic        time_out;
    logic        delay_trigger;
    logic [12:0] delay_n;
    logic [9:0]  leds;
    logic [15:0] bcd;
    logic        false_start;
    logic        overflow;
    logic        busy;

    modport master (
        input  start, react, time_out,
        output delay_trigger, delay_n, leds, bcd, false_start, overflow, busy
    );

    modport slave (
        output start, react, time_out,
        input  delay_trigger, delay_n, leds, bcd, false_start, overflow, busy
    );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction-timer controller: LED countdown, random hold-off via the delay
// stage, then BCD reaction-time measurement (clk is the 1 kHz tick).
module reaction_ctrl #(
    parameter int unsigned STEP_MS   = 500,
    parameter int unsigned MIN_DELAY = 250,
    parameter logic [12:0] LFSR_SEED = 13'h0001
) (
    input  logic            clk,
    input  logic            rst_n,
    reaction_ctrl_if.master bus
);

    localparam int unsigned STEP_W = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LIGHTS,
        RAND_WAIT,
        GO,
        DONE,
        FALSE_START
    } state_t;

    state_t              state, state_nxt;
    logic [STEP_W-1:0]   step;
    logic [9:0]          leds_r;
    logic [15:0]         bcd_r;
    logic [15:0]         bcd_inc;
    logic [12:0]         delay_n_r;
    logic [12:0]         lfsr;
    logic                fs_r;
    logic                ov_r;
    logic                start_q;
    logic                react_q;
    logic                start_rise;
    logic                react_rise;
    logic                step_end;
    logic                leds_full;
    logic                bcd_max;
    logic                carry;

    assign start_rise = bus.start & ~start_q;
    assign react_rise = bus.react & ~react_q;
    assign step_end   = (step == STEP_W'(STEP_MS - 1));
    assign leds_full  = (leds_r == '1);
    assign bcd_max    = (bcd_r == 16'h9999);

    // Ripple BCD increment: a digit at 9 wraps to 0 and passes the carry up.
    always_comb begin
        carry   = 1'b1;
        bcd_inc = bcd_r;
        for (int unsigned i = 0; i < 4; i++) begin
            if (carry) begin
                if (bcd_r[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = bcd_r[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, FALSE_START: begin
                if (start_rise) state_nxt = LIGHTS;
            end
            LIGHTS: begin
                if (react_rise)                state_nxt = FALSE_START;
                else if (step_end && leds_full) state_nxt = RAND_WAIT;
            end
            RAND_WAIT: begin
                if (react_rise)        state_nxt = FALSE_START;
                else if (bus.time_out) state_nxt = GO;
            end
            GO: begin
                if (react_rise || bcd_max) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers; LFSR and edge detectors run in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step      <= '0;
            leds_r    <= '0;
            bcd_r     <= '0;
            delay_n_r <= '0;
            fs_r      <= 1'b0;
            ov_r      <= 1'b0;
            lfsr      <= LFSR_SEED;
            start_q   <= 1'b0;
            react_q   <= 1'b0;
        end else begin
            start_q <= bus.start;
            react_q <= bus.react;
            lfsr    <= {lfsr[11:0], lfsr[12] ^ lfsr[3] ^ lfsr[2] ^ lfsr[0]};
            case (state)
                IDLE, DONE, FALSE_START: begin
                    if (start_rise) begin
                        leds_r <= 10'b00_0000_0001;
                        step   <= '0;
                        bcd_r  <= '0;
                        fs_r   <= 1'b0;
                        ov_r   <= 1'b0;
                    end
                end
                LIGHTS: begin
                    if (react_rise) begin
                        leds_r <= '0;
                        fs_r   <= 1'b1;
                    end else if (step_end) begin
                        step <= '0;
                        if (leds_full) begin
                            delay_n_r <= 13'(MIN_DELAY) + {2'b00, lfsr[10:0]};
                        end else begin
                            leds_r <= {leds_r[8:0], 1'b1};
                        end
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                RAND_WAIT: begin
                    if (react_rise) begin
                        leds_r <= '0;
                        fs_r   <= 1'b1;
                    end else if (bus.time_out) begin
                        leds_r <= '0;
                    end
                end
                GO: begin
                    if (!react_rise) begin
                        if (bcd_max) ov_r  <= 1'b1;
                        else         bcd_r <= bcd_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Trigger decoded from state so an async reset drops it immediately.
    always_comb begin
        bus.delay_trigger = (state == RAND_WAIT);
        bus.busy          = (state == LIGHTS) || (state == RAND_WAIT) || (state == GO);
        bus.delay_n       = delay_n_r;
        bus.leds          = leds_r;
        bus.bcd           = bcd_r;
        bus.false_start   = fs_r;
        bus.overflow      = ov_r;
    end

endmodule

// File: tb/tb_reaction_ctrl.sv
// Scoreboarded bench for reaction_ctrl with a behavioural delay-stage model.
module tb_reaction_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    reaction_ctrl_if bus ();

    reaction_ctrl #(
        .STEP_MS   (500),
        .MIN_DELAY (250),
        .LFSR_SEED (13'h0001)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Delay stage: time_out once N cycles have elapsed with trigger held.
    logic [12:0] dcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  dcnt <= '0;
        else if (!bus.delay_trigger) dcnt <= '0;
        else if (dcnt < bus.delay_n) dcnt <= dcnt + 13'd1;
    end
    always_comb bus.time_out = bus.delay_trigger && (dcnt >= bus.delay_n);

    // Reference LFSR for x^13+x^4+x^3+x+1; m_prev is the value before the last edge.
    logic [12:0] m, m_prev;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m      <= 13'h0001;
            m_prev <= 13'h0001;
        end else begin
            m_prev <= m;
            m      <= {m[11:0], m[12] ^ m[3] ^ m[2] ^ m[0]};
        end
    end

    typedef struct packed {
        logic [15:0] bcd;
        logic        fs;
        logic        ov;
    } result_t;

    result_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] bin2bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Monitor: every busy->idle transition presents a result to score.
    logic busy_q = 1'b0;
    always @(negedge clk) begin
        if (busy_q && !bus.busy) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_result", {14'd0, bus.bcd, bus.false_start, bus.overflow}, 32'hFFFF_FFFF);
            end else begin
                result_t e;
                e = exp_q.pop_front();
                check("sb_result", {14'd0, bus.bcd, bus.false_start, bus.overflow}, {14'd0, e});
            end
        end
        busy_q = bus.busy;
    end

    // Pulse start, follow the LED walk and check trigger timing and delay_n.
    task automatic run_lights();
        int   cnt;
        logic seen;
        seen = 1'b0;
        cnt  = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            cnt++;
            if (cnt == 2) bus.start = 1'b0;
            if (bus.delay_trigger) begin
                seen = 1'b1;
            end else if (((cnt - 1) % 500 == 0) || ((cnt - 1) % 500 == 499)) begin
                check("leds_walk", 32'(bus.leds), 32'((1 << (((cnt - 1) / 500) + 1)) - 1));
            end
        end
        bus.start = 1'b0;
        check("trigger_seen", 32'(seen), 32'd1);
        check("trigger_latency", cnt, 32'd5001);
        check("delay_n_value", 32'(bus.delay_n), 32'(250 + m_prev[10:0]));
        check("delay_n_range", 32'((bus.delay_n >= 13'd250) && (bus.delay_n <= 13'd2297)), 32'd1);
        check("leds_full_wait", 32'(bus.leds), 32'h3FF);
    endtask

    task automatic wait_go();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 2500 && !found; i++) begin
            @(negedge clk);
            if (bus.leds == 10'd0 && bus.busy && !bus.delay_trigger) found = 1'b1;
        end
        check("go_reached", 32'(found), 32'd1);
    endtask

    initial begin
        logic found;
        #(900_000 * 1ns);
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.react = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_leds", 32'(bus.leds), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        check("rst_trigger", 32'(bus.delay_trigger), 32'd0);
        check("rst_delay_n", 32'(bus.delay_n), 32'd0);
        check("rst_flags", {29'd0, bus.false_start, bus.overflow, bus.busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal run: react 237 cycles after GO begins.
        run_lights();
        wait_go();
        repeat (237) @(negedge clk);
        exp_q.push_back('{bcd: 16'h0237, fs: 1'b0, ov: 1'b0});
        bus.react = 1'b1;
        @(negedge clk);
        check("done_busy", 32'(bus.busy), 32'd0);
        bus.react = 1'b0;
        repeat (3) @(negedge clk);

        // False start during LIGHTS at leds=007h.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (bus.leds == 10'h007) found = 1'b1;
        end
        check("leds_007_reached", 32'(found), 32'd1);
        exp_q.push_back('{bcd: 16'h0000, fs: 1'b1, ov: 1'b0});
        bus.react = 1'b1;
        @(negedge clk);
        check("fs_leds", 32'(bus.leds), 32'd0);
        check("fs_flag", 32'(bus.false_start), 32'd1);
        bus.react = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.delay_trigger) found = 1'b1;
        end
        check("fs_no_trigger", 32'(found), 32'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("restart_leds", 32'(bus.leds), 32'h001);
        check("restart_fs_clear", 32'(bus.false_start), 32'd0);

        // React on the cycle time_out first rises.
        found = 1'b0;
        for (int i = 0; i < 8000 && !found; i++) begin
            @(negedge clk);
            if (bus.time_out) found = 1'b1;
        end
        check("time_out_seen", 32'(found), 32'd1);
        exp_q.push_back('{bcd: 16'h0000, fs: 1'b1, ov: 1'b0});
        bus.react = 1'b1;
        @(negedge clk);
        check("tie_trigger", 32'(bus.delay_trigger), 32'd0);
        check("tie_bcd", 32'(bus.bcd), 32'd0);
        check("tie_fs", 32'(bus.false_start), 32'd1);
        bus.react = 1'b0;
        repeat (3) @(negedge clk);

        // No react: saturate at 9999 with carries checked on the way.
        run_lights();
        wait_go();
        exp_q.push_back('{bcd: 16'h9999, fs: 1'b0, ov: 1'b1});
        for (int k = 1; k <= 9999; k++) begin
            @(negedge clk);
            if (k == 9 || k == 10 || k == 99 || k == 100 || k == 999 || k == 1000 || k == 9999)
                check($sformatf("bcd_count_%0d", k), 32'(bus.bcd), 32'(bin2bcd(k)));
        end
        check("ovf_not_yet", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        repeat (3) @(negedge clk);

        // Asynchronous reset in RAND_WAIT.
        run_lights();
        repeat (10) @(negedge clk);
        check("pre_reset_trigger", 32'(bus.delay_trigger), 32'd1);
        exp_q.push_back('{bcd: 16'h0000, fs: 1'b0, ov: 1'b0});
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", {21'd0, bus.delay_trigger, bus.leds, bus.busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_lights();
        wait_go();
        repeat (5) @(negedge clk);
        exp_q.push_back('{bcd: 16'h0005, fs: 1'b0, ov: 1'b0});
        bus.react = 1'b1;
        @(negedge clk);
        bus.react = 1'b0;
        repeat (5) @(negedge clk);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
